// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: opcodes, ALU operation codes, instruction layout, FSM states.
// Holds no logic of its own, so it adds no latency and applies no backpressure.
package alu_pkg;

    localparam logic [3:0] OPC_ADD  = 4'h0;
    localparam logic [3:0] OPC_SUB  = 4'h1;
    localparam logic [3:0] OPC_AND  = 4'h2;
    localparam logic [3:0] OPC_OR   = 4'h3;
    localparam logic [3:0] OPC_ADDI = 4'h4;
    localparam logic [3:0] OPC_SUBI = 4'h5;
    localparam logic [3:0] OPC_ANDI = 4'h6;
    localparam logic [3:0] OPC_ORI  = 4'h7;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Field order matches Instr[31:0] from the MSB down.
    typedef struct packed {
        logic [3:0]  opc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } instr_t;

    function automatic logic opc_legal(input logic [3:0] opc);
        return ~opc[3];
    endfunction

    // ADD/SUB/ADDI/SUBI are the only ops whose carry/borrow is architectural.
    function automatic logic opc_arith(input logic [3:0] opc);
        return ~opc[3] & ~opc[1];
    endfunction

    function automatic logic [31:0] ext_imm(input logic [3:0] opc, input logic [15:0] imm);
        if (opc == OPC_ADDI || opc == OPC_SUBI) begin
            return {{16{imm[15]}}, imm};
        end
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16-entry register file with R0 hardwired to zero, two operand read ports and a debug read port.
// Reads are combinational, writes land on the next clock edge; no backpressure.
module alu_regfile #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    ra_addr,
    output logic [DW-1:0] ra_dat,
    input  logic [3:0]    rb_addr,
    output logic [DW-1:0] rb_dat,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_dat,
    input  logic          wr_vld,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_dat
);

    logic [DW-1:0] regs_q [16];
    logic [DW-1:0] regs_d [16];

    // R0 is never written, so it keeps its reset value of zero forever.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_vld && wr_addr != 4'd0) begin
            regs_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ra_dat  = regs_q[ra_addr];
    assign rb_dat  = regs_q[rb_addr];
    assign dbg_dat = regs_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one instruction at a time through an external ALU: accept, execute, write back.
// Done fires 2 cycles after the accepting edge; InReady is low while busy (one instruction per 3 cycles).
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          InValid,
    output logic          InReady,
    input  logic [31:0]   Instr,
    output logic [1:0]    ALUOp,
    output logic [DW-1:0] SrcA,
    output logic [DW-1:0] SrcB,
    input  logic [DW-1:0] ALUout,
    input  logic          flag,
    output logic          Done,
    output logic [DW-1:0] Result,
    output logic          FlagOut,
    output logic          Err,
    input  logic [3:0]    DbgAddr,
    output logic [DW-1:0] DbgData
);

    logic [1:0]    state_q,    state_d;
    instr_t        instr_q,    instr_d;
    logic [DW-1:0] alu_res_q,  alu_res_d;
    logic          alu_flag_q, alu_flag_d;
    logic          done_q,     done_d;
    logic [DW-1:0] result_q,   result_d;
    logic          err_q,      err_d;
    logic          flag_q,     flag_d;

    logic [DW-1:0] ra_dat;
    logic [DW-1:0] rb_dat;
    logic          legal;
    logic          in_exec;
    logic          wr_vld;

    assign legal   = opc_legal(instr_q.opc);
    assign in_exec = (state_q == ST_EXEC);
    assign wr_vld  = (state_q == ST_WB) && legal;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_res_d  = alu_res_q;
        alu_flag_d = alu_flag_q;
        done_d     = 1'b0;
        result_d   = result_q;
        err_d      = err_q;
        flag_d     = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    instr_d = instr_t'(Instr);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_res_d  = ALUout;
                alu_flag_d = flag;
                state_d    = ST_WB;
            end
            ST_WB: begin
                done_d   = 1'b1;
                result_d = alu_res_q;
                err_d    = ~legal;
                if (legal && opc_arith(instr_q.opc)) begin
                    flag_d = alu_flag_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alu_res_q  <= '0;
            alu_flag_q <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_res_q  <= alu_res_d;
            alu_flag_q <= alu_flag_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_q      <= err_d;
            flag_q     <= flag_d;
        end
    end

    alu_regfile #(
        .DW(DW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (instr_q.rs1),
        .ra_dat   (ra_dat),
        .rb_addr  (instr_q.rs2),
        .rb_dat   (rb_dat),
        .dbg_addr (DbgAddr),
        .dbg_dat  (DbgData),
        .wr_vld   (wr_vld),
        .wr_addr  (instr_q.rd),
        .wr_dat   (alu_res_q)
    );

    // Operand buses idle at zero so the external ALU sees quiet inputs between instructions.
    assign InReady = (state_q == ST_IDLE);
    assign ALUOp   = in_exec ? instr_q.opc[1:0] : ALU_ADD;
    assign SrcA    = in_exec ? ra_dat : '0;
    assign SrcB    = in_exec ? (instr_q.opc[2] ? ext_imm(instr_q.opc, instr_q.imm) : rb_dat) : '0;
    assign Done    = done_q;
    assign Result  = result_q;
    assign FlagOut = flag_q;
    assign Err     = err_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: DW, 32, datapath width (only 32 supported; imm16 extension assumes it).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: InValid  in  1  instruction offered.
REQ-005 SHALL have port: InReady  out  1  sequencer can accept instruction.
REQ-006 SHALL have port: Instr  in  32  [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm16.
REQ-007 SHALL have ports: ALUOp  out  2, SrcA  out  DW, SrcB  out  DW; operation and operands driven to the external ALU.
REQ-008 SHALL have ports: ALUout  in  DW, flag  in  1; combinational ALU result and bit-32 carry/borrow.
REQ-009 SHALL have port: Done  out  1  one-cycle pulse at instruction completion.
REQ-010 SHALL have ports: Result  out  DW  completed result; FlagOut  out  1  sticky carry flag; Err  out  1  illegal opcode, valid with Done.
REQ-011 SHALL have ports: DbgAddr  in  4, DbgData  out  DW; combinational register-file read for debug.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; InReady = (state==IDLE).
REQ-013 SHALL accept Instr on InValid&&InReady edge, latch it, enter EXEC; InValid with InReady low is ignored (no queueing).
REQ-014 SHALL in EXEC drive ALUOp=opcode[1:0], SrcA=R[rs1], SrcB = opcode[2] ? ext(imm16) : R[rs2]; latch ALUout and flag at end of EXEC.
REQ-015 SHALL extend imm16 by sign for opcodes 0x4 ADDI and 0x5 SUBI, by zero for 0x6 ANDI and 0x7 ORI.
REQ-016 SHALL treat opcodes 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR as register-register; 0x8-0xF illegal.
REQ-017 SHALL in WB pulse Done for exactly one cycle with Result = latched ALUout, Err = illegal; Result, Err held until next Done.
REQ-018 SHALL write R[rd] in WB only when opcode legal and rd != 0; R0 reads 0 always, writes discarded.
REQ-019 SHALL update FlagOut in WB only for ADD/SUB/ADDI/SUBI; AND/OR variants and illegal opcodes leave it unchanged.
REQ-020 SHALL on illegal opcode still traverse EXEC and WB (Done=1, Err=1), with no register or flag update.
REQ-021 SHALL give fixed latency: Done asserted 2 cycles after the accepting edge; throughput one instruction per 3 cycles.
REQ-022 SHALL reflect a WB write in DbgData from the cycle after WB; rs1==rs2==rd permitted (operands read in EXEC, before write).
REQ-023 SHALL drive ALUOp=0, SrcA=0, SrcB=0 outside EXEC.

Reset
REQ-024 SHALL on rst_n low immediately force state IDLE, all 16 registers 0, Result 0, FlagOut 0, Err 0, Done 0, latched Instr 0.
REQ-025 SHALL abort any in-flight instruction on reset with no writeback and no Done; InReady=1 during and after reset.

Structure
REQ-026 SHALL place opcode encodings, ALUOp codes, Instr field positions and FSM state enum in shared package alu_pkg.
REQ-027 SHALL implement the register file as sub-module alu_regfile (16x32, two combinational read ports plus debug read port, one synchronous write port, async reset).
REQ-028 SHALL keep the ALU external, connected only through ALUOp/SrcA/SrcB/ALUout/flag.

Verification
REQ-029 SHALL cover: ADDI r1,r0,0x0005 -> Done 2 cycles after accept, Result 0x00000005, DbgData[r1]=5, FlagOut 0.
REQ-030 SHALL cover: ADDI r2,r0,7; SUB r3,r1,r2 -> Result 0xFFFFFFFE, FlagOut 1.
REQ-031 SHALL cover: ADDI r4,r0,0xFFFF -> r4=0xFFFFFFFF; ADD r5,r4,r1 -> Result 0x00000004, FlagOut 1; ORI r6,r0,0xFFFF -> r6=0x0000FFFF, FlagOut still 1.
REQ-032 SHALL cover: opcode 0xA with rd=1 -> Done=1, Err=1, r1 unchanged (5), FlagOut unchanged.
REQ-033 SHALL cover: ADDI r0,r0,0x1234 -> Result 0x00001234, DbgData[r0]=0; InValid held high continuously -> one accept per 3 cycles.
REQ-034 SHALL cover: rst_n low during EXEC of ADDI r7,r0,9 -> no Done, r7=0, InReady=1, all outputs at reset values.
